// File: rtl/adc_stim_gen.sv
// ADC/pixel-stream emulator: derived pixel and word clocks plus framed multi-channel pattern data.
// Define ADC_STIM_HANDSHAKE_EN to add a frame_req/frame_ack single-frame handshake.
module adc_stim_gen #(
  parameter int DATA_W       = 6,
  parameter int NCH          = 1,
  parameter int HALF_DIV     = 2,
  parameter int PIX_PER_WORD = 3,
  parameter int COLS         = 16,
  parameter int ROWS         = 8,
  parameter int LINE_GAP     = 2
) (
  input  logic                    sys_clk,
  input  logic                    FPGA_rst_n,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [DATA_W-1:0]       const_val,
`ifdef ADC_STIM_HANDSHAKE_EN
  input  logic                    frame_req,
  output logic                    frame_ack,
`endif
  output logic                    pix_clk,
  output logic                    data_clk,
  output logic [NCH*DATA_W-1:0]   data,
  output logic                    data_val,
  output logic                    frame_start,
  output logic                    line_end,
  output logic                    busy
);

  localparam int HW = HALF_DIV * PIX_PER_WORD;
  localparam int WP = 2 * HW;
  localparam int TW = $clog2(WP);
  localparam int CW = $clog2(COLS + LINE_GAP + 1);
  localparam int RW = $clog2(ROWS + 1);
  localparam logic [TW-1:0] T_LAST   = TW'(WP - 1);
  localparam logic [TW-1:0] T_MID    = TW'(HW - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [15:0]   SEED     = 16'hACE1;

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP, DONE} state_t;

  state_t                state, state_nxt;
  logic [TW-1:0]         t, t_nxt;
  logic [CW-1:0]         col, col_nxt;
  logic [RW-1:0]         row, row_nxt;
  logic                  run_nxt, pix_nxt, dclk_nxt, upd, first, out_last, start_ok, fb;
  logic [DATA_W-1:0]     base, base_cur, walk;
  logic [15:0]           lfsr, lfsr_cur;
  logic [1:0]            mode_q, eff_mode;
  logic [NCH*DATA_W-1:0] patt;

`ifdef ADC_STIM_HANDSHAKE_EN
  logic req_q;
  assign start_ok = frame_req & ~req_q;
`else
  assign start_ok = 1'b1;
`endif

  // Word sequencing: col counts active words in ACTIVE and blanking words in GAP.
  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    state_nxt = state;
    t_nxt     = t;
    col_nxt   = col;
    row_nxt   = row;
    case (state)
      IDLE: if (en && start_ok) state_nxt = ACTIVE;
      ACTIVE, GAP: begin
        t_nxt = (t == T_LAST) ? '0 : t + 1'b1;
        if (t == T_LAST) begin
          if (state == ACTIVE && col != COL_LAST) col_nxt = col + 1'b1;
          else if (state == ACTIVE && LINE_GAP > 0) begin
            col_nxt   = '0;
            state_nxt = GAP;
          end else if (state == GAP && col != GAP_LAST) col_nxt = col + 1'b1;
          else begin
            col_nxt   = '0;
            state_nxt = ACTIVE;
            if (row != ROW_LAST) row_nxt = row + 1'b1;
            else begin
              row_nxt = '0;
`ifdef ADC_STIM_HANDSHAKE_EN
              state_nxt = DONE;
`endif
            end
          end
        end
      end
`ifdef ADC_STIM_HANDSHAKE_EN
      DONE: if (!frame_req) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
    if (!en) begin
      state_nxt = IDLE;
      t_nxt     = '0;
      col_nxt   = '0;
      row_nxt   = '0;
    end
  end

  assign run_nxt  = (state_nxt == ACTIVE) || (state_nxt == GAP);
  assign pix_nxt  = run_nxt && ((int'(t_nxt) % (2 * HALF_DIV)) < HALF_DIV);
  assign dclk_nxt = run_nxt && (int'(t_nxt) < HW);
  assign upd      = en && (state == ACTIVE || state == GAP) && (t == T_MID);
  assign first    = (state == ACTIVE) && (row == '0) && (col == '0);
  assign eff_mode = first ? mode : mode_q;
  assign base_cur = first ? '0 : base;
  assign lfsr_cur = first ? SEED : lfsr;
  assign fb       = lfsr_cur[0] ^ lfsr_cur[2] ^ lfsr_cur[3] ^ lfsr_cur[5];
  assign walk     = DATA_W'(1) << (int'(col) % DATA_W);

  always_comb begin
    patt = '0;
    for (int c = 0; c < NCH; c++) begin
      case (eff_mode)
        2'd0:    patt[c*DATA_W +: DATA_W] = base_cur + DATA_W'(c);
        2'd1:    patt[c*DATA_W +: DATA_W] = lfsr_cur[DATA_W-1:0] ^ DATA_W'(c);
        2'd2:    patt[c*DATA_W +: DATA_W] = const_val;
        default: patt[c*DATA_W +: DATA_W] = walk;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!FPGA_rst_n) begin
      state <= IDLE;
      t     <= '0;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
    end
  end

  // Data changes on the data_clk falling edge so it is stable around each rising edge.
  always_ff @(posedge sys_clk) begin
    if (!FPGA_rst_n) begin
      pix_clk     <= 1'b0;
      data_clk    <= 1'b0;
      data        <= '0;
      data_val    <= 1'b0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      busy        <= 1'b0;
      out_last    <= 1'b0;
      base        <= '0;
      lfsr        <= SEED;
      mode_q      <= '0;
`ifdef ADC_STIM_HANDSHAKE_EN
      req_q       <= 1'b0;
      frame_ack   <= 1'b0;
`endif
    end else begin
      pix_clk     <= pix_nxt;
      data_clk    <= dclk_nxt;
      busy        <= (state_nxt != IDLE);
      frame_start <= 1'b0;
      line_end    <= run_nxt && out_last && (t_nxt == T_MID);
`ifdef ADC_STIM_HANDSHAKE_EN
      req_q       <= frame_req;
      frame_ack   <= (state_nxt == DONE);
`endif
      if (!run_nxt) begin
        data_val <= 1'b0;
        out_last <= 1'b0;
      end else if (upd) begin
        data_val <= (state == ACTIVE);
        out_last <= (state == ACTIVE) && (col == COL_LAST);
        if (state == ACTIVE) begin
          data        <= patt;
          frame_start <= first;
          base        <= base_cur + 1'b1;
          lfsr        <= {fb, lfsr_cur[15:1]};
          if (first) mode_q <= mode;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_stim_gen.sv
// Self-checking bench for adc_stim_gen: randomized directed sequence against a frame-arithmetic model.
module tb_adc_stim_gen;

  localparam int DATA_W = 6, NCH = 4, HALF_DIV = 2, PIX_PER_WORD = 3;
  localparam int COLS = 16, ROWS = 8, LINE_GAP = 2;
  localparam int HW = HALF_DIV * PIX_PER_WORD, WP = 2 * HW;
  localparam int WPR = COLS + LINE_GAP, WPF = ROWS * WPR;

  logic                  sys_clk = 1'b0;
  logic                  FPGA_rst_n, en;
  logic [1:0]            mode;
  logic [DATA_W-1:0]     const_val;
  logic                  pix_clk, data_clk, data_val, frame_start, line_end, busy;
  logic [NCH*DATA_W-1:0] data;

  adc_stim_gen #(
    .DATA_W(DATA_W), .NCH(NCH), .HALF_DIV(HALF_DIV), .PIX_PER_WORD(PIX_PER_WORD),
    .COLS(COLS), .ROWS(ROWS), .LINE_GAP(LINE_GAP)
  ) dut (
    .sys_clk(sys_clk), .FPGA_rst_n(FPGA_rst_n), .en(en), .mode(mode), .const_val(const_val),
    .pix_clk(pix_clk), .data_clk(data_clk), .data(data), .data_val(data_val),
    .frame_start(frame_start), .line_end(line_end), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int n_asrt = 0, n_fail = 0;

  // Reference model state: s counts sys_clk cycles since the enabling edge.
  int                    s = 0;
  bit                    running = 1'b0;
  int                    frame_mode = 0;
  logic [NCH*DATA_W-1:0] exp_data = '0;
  logic                  exp_val = 1'b0, exp_pix, exp_dclk, exp_fs, exp_le, exp_busy;
  logic [15:0]           lfsr_seq [COLS*ROWS];

  function automatic logic [DATA_W-1:0] ref_word(int m, int k, int pos, int c);
    case (m)
      0:       return DATA_W'((k + c) % (1 << DATA_W));
      1:       return lfsr_seq[k][DATA_W-1:0] ^ DATA_W'(c);
      2:       return const_val;
      default: return DATA_W'(1) << (pos % DATA_W);
    endcase
  endfunction

  task automatic model_edge();
    int ph, w, fw, pos, k;
    exp_fs = 1'b0;
    exp_le = 1'b0;
    if (!FPGA_rst_n) begin
      running  = 1'b0;
      exp_data = '0;
      exp_val  = 1'b0;
    end else if (!en) begin
      running = 1'b0;
      exp_val = 1'b0;
    end else if (!running) begin
      running = 1'b1;
      s = 0;
    end else s++;
    exp_busy = running;
    exp_pix  = 1'b0;
    exp_dclk = 1'b0;
    if (running) begin
      ph  = s % WP;
      w   = s / WP;
      fw  = w % WPF;
      pos = fw % WPR;
      exp_pix  = (ph % (2 * HALF_DIV)) < HALF_DIV;
      exp_dclk = ph < HW;
      if (ph == HW) begin
        if (fw == 0) begin
          frame_mode = int'(mode);
          exp_fs = 1'b1;
        end
        exp_val = (pos < COLS);
        if (exp_val) begin
          k = (fw / WPR) * COLS + pos;
          for (int c = 0; c < NCH; c++) exp_data[c*DATA_W +: DATA_W] = ref_word(frame_mode, k, pos, c);
        end
      end
      if (ph == HW - 1 && w >= 1 && ((w - 1) % WPF) % WPR == COLS - 1) exp_le = 1'b1;
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    check("pix_clk", 32'(pix_clk), 32'(exp_pix));
    check("data_clk", 32'(data_clk), 32'(exp_dclk));
    check("busy", 32'(busy), 32'(exp_busy));
    check("data_val", 32'(data_val), 32'(exp_val));
    check("frame_start", 32'(frame_start), 32'(exp_fs));
    check("line_end", 32'(line_end), 32'(exp_le));
    check("data", 32'(data), 32'(exp_data));
  endtask

  initial begin
    int unsigned l, b;
    int guard;
    l = 32'hACE1;
    for (int k = 0; k < COLS * ROWS; k++) begin
      lfsr_seq[k] = 16'(l);
      b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
      l = (l >> 1) | (b << 15);
    end

    FPGA_rst_n = 1'b0;
    en         = 1'b0;
    mode       = 2'd0;
    const_val  = DATA_W'($urandom);
    repeat (3) tick();
    FPGA_rst_n = 1'b1;
    repeat (2) tick();

    // Counter frames: wrap at word 63 and restart at the next frame.
    en = 1'b1;
    repeat (WPF * WP + 200) tick();

    // LFSR requested mid-frame takes effect at the next frame, then constant likewise.
    mode = 2'd1;
    repeat (WPF * WP - 200 + HW + 5 * WP) tick();
    mode      = 2'd2;
    const_val = DATA_W'($urandom);
    repeat (WPF * WP) tick();

    // Walking one selected mid-frame, then en dropped and restored.
    mode = 2'd3;
    repeat ($urandom_range(20, 200)) tick();
    en = 1'b0;
    repeat ($urandom_range(1, 5)) tick();
    en = 1'b1;
    repeat (2 * WPR * WP + 50) tick();

    // Reset pulse during blanking; restart in LFSR mode shows the seed was restored.
    mode  = 2'd1;
    guard = 0;
    while (!(running && ((s / WP) % WPF) % WPR >= COLS) && guard < 2000) begin
      tick();
      guard++;
    end
    check("reach_gap", 32'(guard < 2000), 32'd1);
    repeat ($urandom_range(0, 10)) tick();
    FPGA_rst_n = 1'b0;
    tick();
    FPGA_rst_n = 1'b1;
    repeat (2 * WPR * WP) tick();

    en = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
